// File: rtl/axi7seg_pkg.sv
// Shared definitions for the 7-segment AXI4-Lite master and slave.
// Register map, response codes and master sequencing enums.
package axi7seg_pkg;

    localparam int ADDR_SEG = 0;
    localparam int ADDR_DP  = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } mst_state_t;

    typedef enum logic [1:0] {
        STEP_SEG_WR,
        STEP_DP_WR,
        STEP_SEG_RD,
        STEP_DP_RD
    } step_t;

endpackage

// File: rtl/axi_7seg_master.sv
// AXI4-Lite initiator writing a full display image (SEG then DP)
// into axi_7seg_cntr, with optional read-back verification.
module axi_7seg_master
    import axi7seg_pkg::*;
#(
    parameter int NDISP      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter bit VERIFY     = 1'b1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [NDISP*4-1:0]        upd_digits,
    input  logic [NDISP-1:0]          upd_dp,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_step,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam logic [ADDR_WIDTH-1:0] A_SEG = ADDR_WIDTH'(ADDR_SEG);
    localparam logic [ADDR_WIDTH-1:0] A_DP  = ADDR_WIDTH'(ADDR_DP);

    mst_state_t              r_state;
    step_t                   r_step;
    logic                    r_upd_ready;
    logic                    r_done;
    logic                    r_err;
    logic [1:0]              r_err_step;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [DATA_WIDTH-1:0]   r_seg_word;
    logic [DATA_WIDTH-1:0]   r_dp_word;

    logic                    w_aw_ok;
    logic                    w_w_ok;
    logic [DATA_WIDTH-1:0]   w_rexp;
    logic                    w_rbad;

    // Either half of the write may already be done from an earlier cycle.
    assign w_aw_ok = r_aw_done | (r_awvalid & awready);
    assign w_w_ok  = r_w_done  | (r_wvalid  & wready);
    assign w_rexp  = (r_step == STEP_SEG_RD) ? r_seg_word : r_dp_word;
    assign w_rbad  = (rresp != RESP_OKAY) || (rdata != w_rexp);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_step      <= STEP_SEG_WR;
            r_upd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_step  <= 2'd0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_seg_word  <= '0;
            r_dp_word   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (upd_valid && r_upd_ready) begin
                        r_seg_word  <= DATA_WIDTH'(upd_digits);
                        r_dp_word   <= DATA_WIDTH'(upd_dp);
                        r_err       <= 1'b0;
                        r_err_step  <= 2'd0;
                        r_step      <= STEP_SEG_WR;
                        r_upd_ready <= 1'b0;
                        r_awaddr    <= A_SEG;
                        r_wdata     <= DATA_WIDTH'(upd_digits);
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_state     <= WADDR;
                    end
                end
                WADDR: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= WRESP;
                    end else begin
                        r_aw_done <= w_aw_ok;
                        r_w_done  <= w_w_ok;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        if (bresp != RESP_OKAY) begin
                            r_err      <= 1'b1;
                            r_err_step <= r_step;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else if (r_step == STEP_SEG_WR) begin
                            r_step    <= STEP_DP_WR;
                            r_awaddr  <= A_DP;
                            r_wdata   <= r_dp_word;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WADDR;
                        end else if (VERIFY) begin
                            r_step    <= STEP_SEG_RD;
                            r_araddr  <= A_SEG;
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        if (w_rbad) begin
                            r_err      <= 1'b1;
                            r_err_step <= r_step;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else if (r_step == STEP_SEG_RD) begin
                            r_step    <= STEP_DP_RD;
                            r_araddr  <= A_DP;
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_upd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Keep ready low while reset is held, high at once on release.
    assign upd_ready = r_upd_ready & nrst;
    assign done      = r_done;
    assign err       = r_err;
    assign err_step  = r_err_step;
    assign awaddr    = r_awaddr;
    assign awprot    = 3'b000;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = '1;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign araddr    = r_araddr;
    assign arprot    = 3'b000;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

endmodule

// File: tb/tb_axi_7seg_master.sv
// Scoreboard bench for axi_7seg_master: behavioural slave with
// configurable ready delays and fault injection, plus a VERIFY=0 copy.
module tb_axi_7seg_master;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        upd_valid = 1'b0, upd_ready;
    logic [31:0] upd_digits = '0;
    logic [7:0]  upd_dp = '0;
    logic        done, err;
    logic [1:0]  err_step;
    logic [2:0]  awaddr, araddr, awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic        upd_valid1 = 1'b0, upd_ready1;
    logic [31:0] upd_digits1 = '0;
    logic [7:0]  upd_dp1 = '0;
    logic        done1, err1;
    logic [1:0]  err_step1;
    logic [2:0]  awaddr1, araddr1, awprot1, arprot1;
    logic        awvalid1, wvalid1, bvalid1, bready1;
    logic        arvalid1, rready1;
    logic [31:0] wdata1;
    logic [3:0]  wstrb1;
    logic        awready1 = 1'b1, wready1 = 1'b1;
    logic        arready1 = 1'b0, rvalid1 = 1'b0;
    logic [31:0] rdata1 = '0;
    logic [1:0]  bresp1 = 2'b00, rresp1 = 2'b00;

    axi_7seg_master #(.NDISP(8), .ADDR_WIDTH(3), .DATA_WIDTH(32), .VERIFY(1'b1)) dut (
        .clk(clk), .nrst(nrst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_digits(upd_digits), .upd_dp(upd_dp),
        .done(done), .err(err), .err_step(err_step),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    axi_7seg_master #(.NDISP(8), .ADDR_WIDTH(3), .DATA_WIDTH(32), .VERIFY(1'b0)) dut1 (
        .clk(clk), .nrst(nrst),
        .upd_valid(upd_valid1), .upd_ready(upd_ready1),
        .upd_digits(upd_digits1), .upd_dp(upd_dp1),
        .done(done1), .err(err1), .err_step(err_step1),
        .awaddr(awaddr1), .awprot(awprot1), .awvalid(awvalid1), .awready(awready1),
        .wdata(wdata1), .wstrb(wstrb1), .wvalid(wvalid1), .wready(wready1),
        .bresp(bresp1), .bvalid(bvalid1), .bready(bready1),
        .araddr(araddr1), .arprot(arprot1), .arvalid(arvalid1), .arready(arready1),
        .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready1)
    );

    int n_vec = 0;
    int n_miss = 0;
    logic [2:0] sb[$];
    logic [2:0] sb1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural slave for the VERIFY=1 instance
    int aw_dly = 0, w_dly = 0;
    bit err_dp = 0, corrupt = 0;
    int aw_wait, w_wait;
    int n_aw = 0, n_w = 0, n_ar = 0, viol = 0;
    logic have_aw, have_w;
    logic [2:0]  waddr;
    logic [31:0] wd, seg_reg, dp_reg;
    logic p_wpend, p_awpend, p_awhs, p_whs;
    logic [31:0] p_wdata;
    logic [2:0]  p_awaddr;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            awready <= 0; wready <= 0; arready <= 0;
            bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
            have_aw <= 0; have_w <= 0; aw_wait <= 0; w_wait <= 0;
            waddr <= 0; wd <= 0; seg_reg <= 0; dp_reg <= 0;
            p_wpend <= 0; p_awpend <= 0; p_awhs <= 0; p_whs <= 0;
            p_wdata <= 0; p_awaddr <= 0;
        end else begin
            awready <= awvalid && !awready && (aw_wait >= aw_dly);
            wready  <= wvalid && !wready && (w_wait >= w_dly);
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (awvalid && awready) begin
                have_aw <= 1; waddr <= awaddr; n_aw <= n_aw + 1;
            end
            if (wvalid && wready) begin
                have_w <= 1; wd <= wdata; n_w <= n_w + 1;
            end
            if (have_aw && have_w && !bvalid) begin
                have_aw <= 0; have_w <= 0; bvalid <= 1;
                if (err_dp && waddr == 3'd4) bresp <= 2'b10;
                else begin
                    bresp <= 2'b00;
                    if (waddr == 3'd0) seg_reg <= wd;
                    else dp_reg <= wd;
                end
            end else if (bvalid && bready) bvalid <= 0;
            arready <= arvalid && !arready;
            if (arvalid && arready) begin
                n_ar <= n_ar + 1; rvalid <= 1; rresp <= 0;
                rdata <= (araddr == 3'd0) ? (seg_reg ^ (corrupt ? 32'h8 : 32'h0)) : dp_reg;
            end else if (rvalid && rready) rvalid <= 0;
            if (p_wpend && (!wvalid || wdata != p_wdata)) viol <= viol + 1;
            if (p_awpend && (!awvalid || awaddr != p_awaddr)) viol <= viol + 1;
            if (p_awhs && awvalid) viol <= viol + 1;
            if (p_whs && wvalid) viol <= viol + 1;
            p_wpend <= wvalid && !wready;
            p_awpend <= awvalid && !awready;
            p_awhs <= awvalid && awready;
            p_whs <= wvalid && wready;
            p_wdata <= wdata;
            p_awaddr <= awaddr;
        end
    end

    // Always-ready slave for the VERIFY=0 instance
    int n_aw1 = 0, n_w1 = 0, n_arv1 = 0;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) bvalid1 <= 0;
        else begin
            if (bvalid1 && bready1) bvalid1 <= 0;
            else if (awvalid1 && wvalid1) bvalid1 <= 1;
            if (awvalid1 && awready1) n_aw1 <= n_aw1 + 1;
            if (wvalid1 && wready1) n_w1 <= n_w1 + 1;
            if (arvalid1) n_arv1 <= n_arv1 + 1;
        end
    end

    // Monitors: pop expected {err, err_step} whenever done pulses
    always @(negedge clk) begin
        if (nrst && done) begin
            if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else begin
                logic [2:0] e;
                e = sb.pop_front();
                check("done_err", 32'(err), 32'(e[2]));
                check("done_step", 32'(err_step), 32'(e[1:0]));
            end
        end
        if (nrst && done1) begin
            if (sb1.size() == 0) check("sb1_empty", 32'd1, 32'd0);
            else begin
                logic [2:0] e;
                e = sb1.pop_front();
                check("done1_err", 32'(err1), 32'(e[2]));
                check("done1_step", 32'(err_step1), 32'(e[1:0]));
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [7:0] p,
                         input logic e, input logic [1:0] s);
        int t = 0;
        while (!upd_ready && t < 100) begin @(negedge clk); t++; end
        if (!upd_ready) check("ready_timeout", 32'd0, 32'd1);
        upd_digits = d;
        upd_dp = p;
        upd_valid = 1'b1;
        sb.push_back({e, s});
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 300) begin @(negedge clk); t++; end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] d, input logic [7:0] p,
                       input logic e, input logic [1:0] s,
                       input int exp_aw, input int exp_ar, input string tag);
        int aw0 = n_aw, w0 = n_w, ar0 = n_ar, v0 = viol;
        issue(d, p, e, s);
        wait_done();
        @(negedge clk);
        check({tag, "_aw"}, 32'(n_aw - aw0), 32'(exp_aw));
        check({tag, "_w"}, 32'(n_w - w0), 32'(exp_aw));
        check({tag, "_ar"}, 32'(n_ar - ar0), 32'(exp_ar));
        check({tag, "_stable"}, 32'(viol - v0), 32'd0);
    endtask

    initial begin
        int t;
        #1;
        check("rst_ready", 32'(upd_ready), 32'd0);
        check("rst_ctl", {awvalid, wvalid, bready, arvalid, rready, done, err, err_step}, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rel_ready", 32'(upd_ready), 32'd1);
        check("rel_addr", {awaddr, araddr}, 0);
        check("rel_wdata", wdata, 0);
        @(negedge clk);

        run(32'h89ABCDEF, 8'hA5, 1'b0, 2'd0, 2, 2, "basic");
        check("seg_reg", seg_reg, 32'h89ABCDEF);
        check("dp_reg", dp_reg, 32'h000000A5);
        check("digit0", 32'(seg_reg[3:0]), 32'hF);

        aw_dly = 0; w_dly = 5;
        run(32'h01234567, 8'h3C, 1'b0, 2'd0, 2, 2, "wlate");
        check("wlate_seg", seg_reg, 32'h01234567);
        aw_dly = 5; w_dly = 0;
        run(32'hFEDCBA98, 8'hC3, 1'b0, 2'd0, 2, 2, "awlate");
        check("awlate_dp", dp_reg, 32'h000000C3);
        aw_dly = 0;

        err_dp = 1;
        run(32'h11112222, 8'h0F, 1'b1, 2'd1, 2, 0, "bresp");
        check("bresp_errhold", 32'(err), 32'd1);
        err_dp = 0;

        corrupt = 1;
        run(32'h55AA55AA, 8'h81, 1'b0 | 1'b1, 2'd2, 2, 1, "rcorrupt");
        corrupt = 0;

        issue(32'hDEADBEEF, 8'hFF, 1'b0, 2'd0);
        t = 0;
        while (!bready && t < 100) begin @(negedge clk); t++; end
        check("reach_wresp", 32'(bready), 32'd1);
        nrst = 1'b0;
        #1;
        check("mid_rst_ctl", {awvalid, wvalid, bready, arvalid, rready, done, err, err_step, upd_ready}, 0);
        check("mid_rst_addr", {awaddr, araddr}, 0);
        check("mid_rst_wdata", wdata, 0);
        sb.delete();
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("mid_rel_ready", 32'(upd_ready), 32'd1);
        @(negedge clk);
        run(32'h00000001, 8'h00, 1'b0, 2'd0, 2, 2, "post_rst");
        check("post_rst_seg", seg_reg, 32'h00000001);

        upd_digits1 = 32'h12345678;
        upd_dp1 = 8'h0F;
        sb1.push_back(3'b000);
        sb1.push_back(3'b000);
        upd_valid1 = 1'b1;
        t = 0;
        while (!done1 && t < 100) begin @(negedge clk); t++; end
        check("v0_done_a", 32'(done1), 32'd1);
        check("v0_busy_ready", 32'(upd_ready1), 32'd0);
        @(negedge clk);
        check("v0_ready_after", 32'(upd_ready1), 32'd1);
        @(negedge clk);
        check("v0_reaccept", 32'(awvalid1), 32'd1);
        t = 0;
        while (!done1 && t < 100) begin @(negedge clk); t++; end
        check("v0_done_b", 32'(done1), 32'd1);
        upd_valid1 = 1'b0;
        repeat (4) @(negedge clk);
        check("v0_aw", 32'(n_aw1), 32'd4);
        check("v0_w", 32'(n_w1), 32'd4);
        check("v0_ar", 32'(n_arv1), 32'd0);
        check("v0_idle", 32'(upd_ready1), 32'd1);

        check("sb_drained", 32'(sb.size() + sb1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
